// File: rtl/inst_encode_writer_pkg.sv
// Shared RV32I encoder definitions: format codes, base opcodes, request struct
// and an immediate range helper.
package inst_encode_writer_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  // True when v fits a signed field whose sign bit is v[msb].
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
    logic [31:0] t;
    t = $signed(v) >>> msb;
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/inst_encode_writer_comb.sv
// Combinational RV32I field packing with immediate range check.
module inst_encode_writer_comb
  import inst_encode_writer_pkg::*;
(
  input  enc_req_t    i_req,
  output logic [31:0] o_word,
  output logic        o_range_err
);

  logic [31:0] w_imm;
  logic        w_shift;

  assign w_imm = i_req.imm;
  // Only OP-IMM slli/srli/srai carry funct7; loads with funct3 1/5 are plain I-type.
  assign w_shift = (i_req.opcode == OPC_OPIMM) &&
                   ((i_req.funct3 == 3'd1) || (i_req.funct3 == 3'd5));

  always_comb begin
    o_word      = '0;
    o_range_err = 1'b0;
    case (i_req.fmt)
      FMT_R: o_word = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
      FMT_I: begin
        if (w_shift) begin
          o_word      = {i_req.funct7, w_imm[4:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
          o_range_err = (w_imm[31:5] != '0);
        end else begin
          o_word      = {w_imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
          o_range_err = !sext_ok(w_imm, 11);
        end
      end
      FMT_S: begin
        o_word      = {w_imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, w_imm[4:0], i_req.opcode};
        o_range_err = !sext_ok(w_imm, 11);
      end
      FMT_B: begin
        o_word      = {w_imm[12], w_imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                       w_imm[4:1], w_imm[11], i_req.opcode};
        o_range_err = !sext_ok(w_imm, 12) || w_imm[0];
      end
      FMT_U: begin
        o_word      = {w_imm[31:12], i_req.rd, i_req.opcode};
        o_range_err = (w_imm[11:0] != '0);
      end
      FMT_J: begin
        o_word      = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_req.rd, i_req.opcode};
        o_range_err = !sext_ok(w_imm, 20) || w_imm[0];
      end
      default: o_range_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encode_writer.sv
// Encodes decoded instruction fields and streams the words into instruction
// memory at consecutive addresses through a stallable write port.
module inst_encode_writer
  import inst_encode_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err_range,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [ADDR_W:0]   r_cnt;

  enc_req_t    w_req;
  logic [31:0] w_word;
  logic        w_range_err;
  logic        w_accept;
  logic        w_wr_done;
  logic        w_start_ok;

  assign w_req = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  inst_encode_writer_comb u_comb (
    .i_req       (w_req),
    .o_word      (w_word),
    .o_range_err (w_range_err)
  );

  assign mem_we     = (r_state == S_WRITE);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign done       = (r_state == S_DONE);
  assign err_range  = r_err;
  assign word_count = r_cnt;

  // mem_ready feeds in_ready combinationally so the stream sustains 1 word/cycle.
  assign in_ready   = (r_state == S_RUN) || (mem_we && mem_ready && !r_last);
  assign w_accept   = in_valid && in_ready;
  assign w_wr_done  = mem_we && mem_ready;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_start_ok) begin
        r_state <= S_RUN;
        r_addr  <= BASE_ADDR;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end
      if (w_wr_done) begin
        r_addr  <= r_addr + ADDR_W'(4);
        r_cnt   <= r_cnt + 1'b1;
        r_state <= r_last ? S_DONE : S_RUN;
      end
      if (w_accept) begin
        r_wdata <= w_word;
        r_last  <= in_last;
        r_state <= S_WRITE;
        if (w_range_err) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encode_writer.sv
// Directed bench for inst_encode_writer: encodings, streaming, stalls, wrap, reset.
module tb_inst_encode_writer;
  import inst_encode_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_last, mem_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_we, done, err_range;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [16:0] word_count;

  logic        w_in_ready, w_mem_we, w_done, w_err_range;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic [4:0]  w_word_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_encode_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .done(done), .err_range(err_range), .word_count(word_count)
  );

  // Narrow-address copy driven identically, to observe wrap from 0xC.
  inst_encode_writer #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_w (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ready(mem_ready),
    .done(w_done), .err_range(w_err_range), .word_count(w_word_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    in_valid = 1'b1; in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #12;
    chk("rst_we",    32'(mem_we), 0);
    chk("rst_addr",  32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err_range), 0);
    chk("rst_cnt",   32'(word_count), 0);
    chk("rst_rdy",   32'(in_ready), 0);
    chk("rst_addr_w", 32'(w_mem_addr), 32'hC);
    @(negedge clk); rst = 1'b0;

    // addi x1,x0,5 single word, one-cycle latency after accept
    do_start();
    #1 chk("run_rdy", 32'(in_ready), 1);
    req(FMT_I, OPC_OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("addi_we",    32'(mem_we), 1);
    chk("addi_addr",  32'(mem_addr), 0);
    chk("addi_wdata", mem_wdata, 32'h00500093);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("addi_done", 32'(done), 1);
    chk("addi_cnt",  32'(word_count), 1);
    chk("addi_we0",  32'(mem_we), 0);

    // sw / beq / jal streamed back-to-back
    do_start();
    req(FMT_S, OPC_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    @(negedge clk);
    chk("sw_wdata", mem_wdata, 32'h0020A423);
    chk("sw_addr",  32'(mem_addr), 0);
    chk("sw_addr_w", 32'(w_mem_addr), 32'hC);
    #1 chk("b2b_rdy", 32'(in_ready), 1);
    req(FMT_B, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    chk("beq_wdata", mem_wdata, 32'hFE000EE3);
    chk("beq_addr",  32'(mem_addr), 4);
    chk("beq_addr_w", 32'(w_mem_addr), 0);
    req(FMT_J, OPC_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("jal_wdata", mem_wdata, 32'h001000EF);
    chk("jal_addr",  32'(mem_addr), 8);
    chk("jal_addr_w", 32'(w_mem_addr), 4);
    #1 chk("last_rdy", 32'(in_ready), 0);
    @(negedge clk);
    chk("strm_done", 32'(done), 1);
    chk("strm_cnt",  32'(word_count), 3);
    chk("strm_cnt_w", 32'(w_word_count), 3);
    chk("strm_err",  32'(err_range), 0);

    // addi x1,x0,2048 out of range, still written; start clears error
    do_start();
    req(FMT_I, OPC_OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("rng_wdata", mem_wdata, 32'h80000093);
    chk("rng_err",   32'(err_range), 1);
    @(negedge clk);
    chk("rng_err_hold", 32'(err_range), 1);
    do_start();
    chk("rng_err_clr", 32'(err_range), 0);

    // lui x5,0x12345 with three stall cycles; start ignored mid-write
    mem_ready = 1'b0;
    req(FMT_U, OPC_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start = 1'b1;
      #1;
      chk("stl_we",    32'(mem_we), 1);
      chk("stl_addr",  32'(mem_addr), 0);
      chk("stl_wdata", mem_wdata, 32'h123452B7);
      chk("stl_rdy",   32'(in_ready), 0);
      chk("stl_cnt",   32'(word_count), 0);
      @(negedge clk); start = 1'b0;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stl_cnt1", 32'(word_count), 1);
    chk("stl_we0",  32'(mem_we), 0);
    chk("stl_rdy1", 32'(in_ready), 1);

    // srai x3,x1,4 then illegal format
    req(FMT_I, OPC_OPIMM, 3'd5, 7'h20, 5'd3, 5'd1, 5'd0, 32'd4, 1'b0);
    @(negedge clk);
    chk("srai_wdata", mem_wdata, 32'h4040D193);
    chk("srai_addr",  32'(mem_addr), 4);
    chk("srai_err",   32'(err_range), 0);
    req(3'd6, OPC_OP, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'd0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    chk("bad_wdata", mem_wdata, 32'h0);
    chk("bad_err",   32'(err_range), 1);
    @(negedge clk);
    chk("bad_cnt", 32'(word_count), 3);

    // asynchronous reset during a stalled write
    do_start();
    mem_ready = 1'b0;
    req(FMT_R, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    chk("abt_we1", 32'(mem_we), 1);
    chk("r_wdata", mem_wdata, 32'h003100B3);
    #2 rst = 1'b1;
    #1;
    chk("abt_we",   32'(mem_we), 0);
    chk("abt_rdy",  32'(in_ready), 0);
    chk("abt_cnt",  32'(word_count), 0);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
    req(FMT_I, OPC_OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("abt_idle_rdy", 32'(in_ready), 0);
    chk("abt_idle_we",  32'(mem_we), 0);
    in_valid = 1'b0;
    do_start();
    chk("abt_start_rdy", 32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
